chunked_adder: RTL and testbench

Parametrised multi-cycle binary adder. Operands are captured on a start strobe and summed CHUNK bits per clock through a registered carry chain. The block signals completion with a one-cycle done pulse and holds the result until the next operation. It is the sequential, width-generic successor to the single-bit full adder and sits between operand registers and the board-level result display logic on the Cmod A7-35T.

---
 rtl/chunked_adder.sv | 175 +++++++++++++++++
 tb/tb_chunked_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// -----------------------------------------------------------------------------
// chunked_adder
//
// Multi-cycle binary adder. Operands are captured on a start strobe and summed
// CHUNK bits per clock through a registered carry chain. Completion is flagged
// with a one-cycle done pulse; sum/cout/ovf hold the last result until the next
// operation completes.
//
// Optional feature macro: CHUNKED_ADDER_SUB_EN
//   defined   -> 'sub' port exists; sub=1 computes a - b as a + ~b + 1
//                (cin ignored, cout=1 means no borrow).
//   undefined -> no 'sub' port; the block always computes a + b + cin.
//
// Parameters
//   WIDTH  operand / sum width (>= 1)
//   CHUNK  bits added per clock (1..WIDTH, WIDTH multiple of CHUNK)
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request strobe, sampled only in IDLE
//   a, b   in   WIDTH  operands, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   sub    in   1      subtract select (only with CHUNKED_ADDER_SUB_EN)
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse when the result becomes valid
//   sum    out  WIDTH  result, low WIDTH bits
//   cout   out  1      carry out of bit WIDTH-1
//   ovf    out  1      two's-complement overflow
// -----------------------------------------------------------------------------
module chunked_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCH   = WIDTH / CHUNK;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic               r_done;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_res;

   logic               w_capture;
   logic               w_last;
   logic               w_busy;
   logic [WIDTH-1:0]   w_b_in;
   logic               w_cin_in;
   logic [CHUNK:0]     w_csum;
   logic [WIDTH-1:0]   w_res_next;
   logic               w_c_msb;

   // Operand conditioning at capture time: subtraction becomes a + ~b + 1.
`ifdef CHUNKED_ADDER_SUB_EN
   assign w_b_in   = sub ? ~b : b;
   assign w_cin_in = sub ? 1'b1 : cin;
`else
   assign w_b_in   = b;
   assign w_cin_in = cin;
`endif

   // Current chunk: the low CHUNK bits of the operand shift registers.
   assign w_csum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_carry};

   // New chunk enters at the top so that after NCH chunks the LSB chunk
   // has arrived at bit 0.
   assign w_res_next = (r_res >> CHUNK)
                     | (WIDTH'(w_csum[CHUNK-1:0]) << (WIDTH - CHUNK));

   // Carry into the MSB is recovered from the MSB's own sum bit; only
   // meaningful on the final chunk, where bit CHUNK-1 is the operand MSB.
   assign w_c_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_csum[CHUNK-1];

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_last       = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = RUN;
               w_capture    = 1'b1;
            end
         end
         RUN: begin
            w_busy = 1'b1;
            if (r_idx == LAST_IDX) begin
               w_last       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= w_last;
         if (w_capture) begin
            r_idx   <= '0;
            r_carry <= w_cin_in;
         end else if (r_state == RUN) begin
            r_carry <= w_csum[CHUNK];
            if (!w_last) begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end
         if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_csum[CHUNK];
            r_ovf  <= w_c_msb ^ w_csum[CHUNK];
         end
      end
   end

   // Datapath shift registers carry no reset; they are always reloaded on
   // capture and fully shifted before their contents are used.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_a <= a;
         r_b <= w_b_in;
      end else if (r_state == RUN) begin
         r_a   <= r_a >> CHUNK;
         r_b   <= r_b >> CHUNK;
         r_res <= w_res_next;
      end
   end

   assign busy = w_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_adder.sv
module tb_chunked_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   // WIDTH=8, CHUNK=2 instance
   logic       s8_start = 0, s8_cin = 0, s8_sub = 0;
   logic [7:0] s8_a = 0, s8_b = 0;
   logic       o8_busy, o8_done, o8_cout, o8_ovf;
   logic [7:0] o8_sum;

   // WIDTH=1, CHUNK=1 instance
   logic       s1_start = 0, s1_cin = 0, s1_sub = 0;
   logic [0:0] s1_a = 0, s1_b = 0;
   logic       o1_busy, o1_done, o1_cout, o1_ovf;
   logic [0:0] o1_sum;

   // WIDTH=8, CHUNK=1 instance
   logic       s9_start = 0, s9_cin = 0, s9_sub = 0;
   logic [7:0] s9_a = 0, s9_b = 0;
   logic       o9_busy, o9_done, o9_cout, o9_ovf;
   logic [7:0] o9_sum;

   chunked_adder #(.WIDTH(8), .CHUNK(2)) u8 (
      .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b), .cin(s8_cin),
`ifdef CHUNKED_ADDER_SUB_EN
      .sub(s8_sub),
`endif
      .busy(o8_busy), .done(o8_done), .sum(o8_sum), .cout(o8_cout), .ovf(o8_ovf));

   chunked_adder #(.WIDTH(1), .CHUNK(1)) u1 (
      .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
`ifdef CHUNKED_ADDER_SUB_EN
      .sub(s1_sub),
`endif
      .busy(o1_busy), .done(o1_done), .sum(o1_sum), .cout(o1_cout), .ovf(o1_ovf));

   chunked_adder #(.WIDTH(8), .CHUNK(1)) u9 (
      .clk(clk), .rst(rst), .start(s9_start), .a(s9_a), .b(s9_b), .cin(s9_cin),
`ifdef CHUNKED_ADDER_SUB_EN
      .sub(s9_sub),
`endif
      .busy(o9_busy), .done(o9_done), .sum(o9_sum), .cout(o9_cout), .ovf(o9_ovf));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic on unsigned and signed interpretations.
   // Returns {ovf, cout, sum[7:0]}.
   function automatic logic [9:0] ref_add(input int w, input int a, input int b,
                                           input int c, input int s);
      int m, h, sa, sb, u, r;
      logic [9:0] res;
      m = 1 << w;
      h = 1 << (w - 1);
      sa = (a >= h) ? a - m : a;
      sb = (b >= h) ? b - m : b;
      res = '0;
      if (s != 0) begin
         u = a - b;
         r = sa - sb;
         res[8] = (a >= b);
      end else begin
         u = a + b + c;
         r = sa + sb + c;
         res[8] = (u >= m);
      end
      u = ((u % m) + m) % m;
      res[7:0] = u[7:0];
      res[9] = (r > h - 1) || (r < -h);
      return res;
   endfunction

   logic [9:0] last8 = '0;
   logic [9:0] last9 = '0;

   // One WIDTH=8/CHUNK=2 operation; inputs scrambled during RUN, optionally
   // with a stray start pulse two cycles in.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic s, input bit poke);
      logic [9:0] exp;
      exp = ref_add(8, a, b, c, s);
      @(negedge clk);
      s8_a = a; s8_b = b; s8_cin = c; s8_sub = s; s8_start = 1;
      @(posedge clk); #1;
      s8_start = 0;
      chk("busy8_accept", o8_busy, 1);
      for (int i = 1; i <= 4; i++) begin
         if (poke && i == 2) begin
            s8_start = 1; s8_a = ~a; s8_b = a; s8_cin = ~c;
         end else begin
            s8_start = 0; s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom);
         end
         @(posedge clk); #1;
         if (i < 4) begin
            chk("busy8_run", o8_busy, 1);
            chk("done8_early", o8_done, 0);
            chk("hold8", {o8_ovf, o8_cout, o8_sum}, last8);
         end else begin
            chk("busy8_end", o8_busy, 0);
            chk("done8", o8_done, 1);
            chk("result8", {o8_ovf, o8_cout, o8_sum}, exp);
         end
      end
      s8_start = 0;
      last8 = exp;
      @(posedge clk); #1;
      chk("done8_single", o8_done, 0);
      chk("busy8_idle", o8_busy, 0);
      chk("held8", {o8_ovf, o8_cout, o8_sum}, last8);
   endtask

   task automatic op9(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [9:0] exp;
      exp = ref_add(8, a, b, c, 0);
      @(negedge clk);
      s9_a = a; s9_b = b; s9_cin = c; s9_start = 1;
      @(posedge clk); #1;
      s9_start = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i < 8) chk("done9_early", o9_done, 0);
      end
      chk("done9", o9_done, 1);
      chk("busy9_end", o9_busy, 0);
      chk("result9", {o9_ovf, o9_cout, o9_sum}, exp);
      last9 = exp;
   endtask

   initial begin
      logic [9:0] e1, e2;
      logic [2:0] v;
      int dcnt;

      // Reset
      #1 rst = 1;
      #1;
      chk("rst_busy8", o8_busy, 0);
      chk("rst_done8", o8_done, 0);
      chk("rst_res8", {o8_ovf, o8_cout, o8_sum}, 0);
      chk("rst_res9", {o9_ovf, o9_cout, o9_sum}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;

      // Directed cases
      op8(8'h5A, 8'h33, 0, 0, 0);
      op8(8'hFF, 8'h01, 0, 0, 0);
      op8(8'h7F, 8'h00, 1, 0, 0);
      op8(8'h80, 8'h80, 0, 0, 0);
      op8(8'h00, 8'h00, 0, 0, 0);
      // Stray start during RUN is ignored
      op8(8'h12, 8'h34, 1, 0, 1);

`ifdef CHUNKED_ADDER_SUB_EN
      op8(8'h10, 8'h20, 0, 1, 0);
      op8(8'h80, 8'h01, 1, 1, 0);
      op8(8'h44, 8'h44, 0, 0, 0);
`endif

      // Randomized operations
      for (int n = 0; n < 25; n++) begin
         logic s;
`ifdef CHUNKED_ADDER_SUB_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         op8(8'($urandom), 8'($urandom), 1'($urandom), s, (n % 5) == 0);
      end

      // Back-to-back: start held through the done cycle
      e1 = ref_add(8, 8'hA5, 8'h3C, 1, 0);
      e2 = ref_add(8, 8'h81, 8'hFE, 0, 0);
      @(negedge clk);
      s8_a = 8'hA5; s8_b = 8'h3C; s8_cin = 1; s8_sub = 0; s8_start = 1;
      @(posedge clk); #1;
      s8_a = 8'h81; s8_b = 8'hFE; s8_cin = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (i < 4) chk("b2b_done_early1", o8_done, 0);
      end
      chk("b2b_done1", o8_done, 1);
      chk("b2b_result1", {o8_ovf, o8_cout, o8_sum}, e1);
      @(posedge clk); #1;
      s8_start = 0;
      chk("b2b_busy2", o8_busy, 1);
      chk("b2b_done_off", o8_done, 0);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (i < 4) chk("b2b_hold", {o8_ovf, o8_cout, o8_sum}, e1);
      end
      chk("b2b_done2", o8_done, 1);
      chk("b2b_result2", {o8_ovf, o8_cout, o8_sum}, e2);
      last8 = e2;

      // WIDTH=1 full-adder sweep
      for (int k = 0; k < 8; k++) begin
         v = 3'(k);
         e1 = ref_add(1, int'(v[2]), int'(v[1]), int'(v[0]), 0);
         @(negedge clk);
         s1_a = v[2]; s1_b = v[1]; s1_cin = v[0]; s1_start = 1;
         @(posedge clk); #1;
         s1_start = 0;
         chk("busy1", o1_busy, 1);
         @(posedge clk); #1;
         chk("done1", o1_done, 1);
         chk("cs1", {o1_cout, o1_sum}, 16'(int'(v[2]) + int'(v[1]) + int'(v[0])));
         chk("ovf1", o1_ovf, e1[9]);
      end

      // WIDTH=8, CHUNK=1: normal ops, then async reset mid-RUN
      op9(8'hC3, 8'h5A, 0);
      op9(8'($urandom), 8'($urandom), 1'($urandom));
      op9(8'hC3, 8'h5A, 1);
      @(negedge clk);
      s9_a = 8'h77; s9_b = 8'h11; s9_cin = 0; s9_start = 1;
      @(posedge clk); #1;
      s9_start = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1;
      #1;
      chk("abort_busy", o9_busy, 0);
      chk("abort_done", o9_done, 0);
      chk("abort_res", {o9_ovf, o9_cout, o9_sum}, 0);
      @(negedge clk) rst = 0;
      last8 = '0;
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (o9_done) dcnt++;
      end
      chk("abort_no_done", 16'(dcnt), 0);
      chk("abort_idle", o9_busy, 0);
      op9(8'h7F, 8'h01, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
